// File: rtl/cbc_pkg.sv
// Shared types and constants for the CBC chaining controller.
package cbc_pkg;

   localparam int CBC_BLOCK_W = 128;

   localparam logic MODE_DEC = 1'b0;
   localparam logic MODE_ENC = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_OUT   = 3'd4
   } cbc_state_e;

endpackage

// File: rtl/cbc_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry one wrap bit.
module cbc_fifo #(
   parameter int WIDTH = 129,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   always_comb begin
      full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      empty_o = (wr_q == rd_q);
      rdata_o = mem_q[rd_q[AW-1:0]];
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
   end

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (do_push) begin
         mem_d[wr_q[AW-1:0]] = wdata_i;
         wr_d                = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/cbc_chain_ctrl.sv
// CBC chaining controller around a single-block cipher core, one block in flight.
//   state | meaning
//   IDLE  | waiting for IV + mode; chain value not valid
//   READY | IV loaded, waiting for a buffered input block
//   ISSUE | presenting chained block to the core
//   WAIT  | waiting for the core result pulse
//   OUT   | holding result until downstream accepts it
module cbc_chain_ctrl
   import cbc_pkg::*;
#(
   parameter int BLOCK_W = CBC_BLOCK_W,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               enable_i,
   input  logic [BLOCK_W-1:0] iv_i,
   input  logic               mode_i,
   input  logic               ivalid_i,
   output logic               iv_ready_o,
   input  logic [BLOCK_W-1:0] din_i,
   input  logic               dlast_i,
   input  logic               dvalid_i,
   output logic               dready_o,
   output logic               core_start_o,
   output logic [BLOCK_W-1:0] core_din_o,
   input  logic               core_ready_i,
   input  logic               core_valid_i,
   input  logic [BLOCK_W-1:0] core_dout_i,
   output logic [BLOCK_W-1:0] dout_o,
   output logic               dlast_o,
   output logic               dvalid_o,
   input  logic               dready_i,
   output logic [CNT_W-1:0]   blk_cnt_o,
   output logic               busy_o,
   output logic               err_o
);

   cbc_state_e         state_q, state_d;
   logic [BLOCK_W-1:0] chain_q, chain_d;
   logic               mode_q, mode_d;
   logic [BLOCK_W-1:0] cur_q, cur_d;
   logic               cur_last_q, cur_last_d;
   logic [BLOCK_W-1:0] dout_q, dout_d;
   logic               dlast_q, dlast_d;
   logic               dvalid_q, dvalid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [BLOCK_W-1:0] res_q, res_d;
   logic               pend_q, pend_d;

   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic [BLOCK_W:0]   fifo_rdata;
   logic               res_vld;
   logic [BLOCK_W-1:0] res_val;

   assign dready_o = enable_i && !fifo_full;
   assign fifo_pop = enable_i && (state_q == ST_READY) && !fifo_empty;

   cbc_fifo #(
      .WIDTH (BLOCK_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (resetn),
      .push_i  (dvalid_i && dready_o),
      .wdata_i ({dlast_i, din_i}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         chain_q    <= '0;
         mode_q     <= MODE_DEC;
         cur_q      <= '0;
         cur_last_q <= 1'b0;
         dout_q     <= '0;
         dlast_q    <= 1'b0;
         dvalid_q   <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         res_q      <= '0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         chain_q    <= chain_d;
         mode_q     <= mode_d;
         cur_q      <= cur_d;
         cur_last_q <= cur_last_d;
         dout_q     <= dout_d;
         dlast_q    <= dlast_d;
         dvalid_q   <= dvalid_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         res_q      <= res_d;
         pend_q     <= pend_d;
      end
   end

   // A result arriving while disabled is parked in res_q until enable returns.
   assign res_vld = core_valid_i || pend_q;
   assign res_val = core_valid_i ? core_dout_i : res_q;

   always_comb begin
      state_d    = state_q;
      chain_d    = chain_q;
      mode_d     = mode_q;
      cur_d      = cur_q;
      cur_last_d = cur_last_q;
      dout_d     = dout_q;
      dlast_d    = dlast_q;
      dvalid_d   = dvalid_q;
      cnt_d      = cnt_q;
      res_d      = res_q;
      pend_d     = pend_q;
      err_d      = err_q;

      if (enable_i && ((core_valid_i && (state_q != ST_WAIT)) ||
                       (ivalid_i && (state_q != ST_IDLE)))) begin
         err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable_i && ivalid_i) begin
               chain_d = iv_i;
               mode_d  = mode_i;
               cnt_d   = '0;
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (fifo_pop) begin
               cur_d      = fifo_rdata[BLOCK_W-1:0];
               cur_last_d = fifo_rdata[BLOCK_W];
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (enable_i && core_ready_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (enable_i && res_vld) begin
               if (mode_q == MODE_ENC) begin
                  dout_d  = res_val;
                  chain_d = res_val;
               end else begin
                  dout_d  = res_val ^ chain_q;
                  chain_d = cur_q;
               end
               dlast_d  = cur_last_q;
               dvalid_d = 1'b1;
               pend_d   = 1'b0;
               state_d  = ST_OUT;
            end else if (!enable_i && core_valid_i) begin
               res_d  = core_dout_i;
               pend_d = 1'b1;
            end
         end
         ST_OUT: begin
            if (enable_i && dready_i) begin
               dvalid_d = 1'b0;
               cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
               state_d  = dlast_q ? ST_IDLE : ST_READY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      iv_ready_o   = enable_i && (state_q == ST_IDLE);
      core_start_o = enable_i && (state_q == ST_ISSUE);
      busy_o       = (state_q != ST_IDLE) && (state_q != ST_READY);
      core_din_o   = (mode_q == MODE_ENC) ? (cur_q ^ chain_q) : cur_q;
      dout_o       = dout_q;
      dlast_o      = dlast_q;
      dvalid_o     = dvalid_q;
      blk_cnt_o    = cnt_q;
      err_o        = err_q;
   end

endmodule

// File: tb/tb_cbc_chain_ctrl.sv
// Self-checking bench: directed vector table, corner sequences, random traffic vs a CBC reference model.
module tb_cbc_chain_ctrl;

   localparam logic [127:0] K = {16{8'hA5}};

   logic         clk = 1'b0;
   logic         resetn;
   logic         enable_i;
   logic [127:0] iv_i;
   logic         mode_i;
   logic         ivalid_i;
   logic         iv_ready_o;
   logic [127:0] din_i;
   logic         dlast_i;
   logic         dvalid_i;
   logic         dready_o;
   logic         core_start_o;
   logic [127:0] core_din_o;
   logic         core_ready_i;
   logic         core_valid_i;
   logic [127:0] core_dout_i;
   logic [127:0] dout_o;
   logic         dlast_o;
   logic         dvalid_o;
   logic         dready_i;
   logic [15:0]  blk_cnt_o;
   logic         busy_o;
   logic         err_o;

   cbc_chain_ctrl dut (
      .clk          (clk),
      .resetn       (resetn),
      .enable_i     (enable_i),
      .iv_i         (iv_i),
      .mode_i       (mode_i),
      .ivalid_i     (ivalid_i),
      .iv_ready_o   (iv_ready_o),
      .din_i        (din_i),
      .dlast_i      (dlast_i),
      .dvalid_i     (dvalid_i),
      .dready_o     (dready_o),
      .core_start_o (core_start_o),
      .core_din_o   (core_din_o),
      .core_ready_i (core_ready_i),
      .core_valid_i (core_valid_i),
      .core_dout_i  (core_dout_i),
      .dout_o       (dout_o),
      .dlast_o      (dlast_o),
      .dvalid_o     (dvalid_o),
      .dready_i     (dready_i),
      .blk_cnt_o    (blk_cnt_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference model: plain CBC over the stream of accepted blocks and IVs.
   typedef struct {
      logic [127:0] iv;
      logic         mode;
   } ivrec_t;

   ivrec_t       ivq[$];
   logic [128:0] blkq[$];
   logic         need_iv = 1'b1;
   logic [127:0] mchain = '0;
   logic         mmode = 1'b0;
   int           mcnt = 0;
   int           n_in = 0;
   int           n_out = 0;

   task automatic model_reset();
      ivq.delete();
      blkq.delete();
      need_iv = 1'b1;
      mcnt    = 0;
      n_in    = 0;
      n_out   = 0;
   endtask

   task automatic sb_out(input logic [127:0] got, input logic got_last);
      logic [128:0] b;
      logic [127:0] exp;
      ivrec_t       r;
      if (need_iv) begin
         chk("sb_iv_avail", 128'(ivq.size() != 0), 128'(1));
         if (ivq.size() != 0) begin
            r      = ivq.pop_front();
            mchain = r.iv;
            mmode  = r.mode;
         end
         mcnt    = 0;
         need_iv = 1'b0;
      end
      chk("sb_blk_avail", 128'(blkq.size() != 0), 128'(1));
      if (blkq.size() != 0) begin
         b = blkq.pop_front();
         if (mmode) begin
            exp    = (b[127:0] ^ mchain) ^ K;
            mchain = exp;
         end else begin
            exp    = (b[127:0] ^ K) ^ mchain;
            mchain = b[127:0];
         end
         chk("sb_dout", got, exp);
         chk("sb_dlast", 128'(got_last), 128'(b[128]));
         if (mcnt < 65535) mcnt++;
         if (b[128]) need_iv = 1'b1;
      end
      n_out++;
   endtask

   logic         last_iv_hs, last_in_hs, last_out_hs, last_core_hs;
   logic [127:0] last_core_din, last_dout;
   logic         last_dlast;
   logic         inj = 1'b0;
   logic         rnd = 1'b0;

   // One clock: sample handshakes before the edge, then update the core stub at the negedge.
   task automatic cyc();
      ivrec_t r;
      #1;
      last_iv_hs    = ivalid_i && iv_ready_o;
      last_in_hs    = dvalid_i && dready_o;
      last_out_hs   = dvalid_o && dready_i && enable_i && resetn;
      last_core_hs  = core_start_o && core_ready_i;
      last_core_din = core_din_o;
      last_dout     = dout_o;
      last_dlast    = dlast_o;
      if (resetn) begin
         if (last_iv_hs) begin
            r.iv   = iv_i;
            r.mode = mode_i;
            ivq.push_back(r);
         end
         if (last_in_hs) begin
            blkq.push_back({dlast_i, din_i});
            n_in++;
         end
         if (last_out_hs) sb_out(dout_o, dlast_o);
      end
      @(posedge clk);
      @(negedge clk);
      core_valid_i = 1'b0;
      if (last_core_hs || inj) begin
         core_valid_i = 1'b1;
         core_dout_i  = last_core_din ^ K;
         inj          = 1'b0;
      end
      if (last_out_hs) chk("sb_cnt", 128'(blk_cnt_o), 128'(mcnt));
      if (rnd) begin
         dready_i     = 1'($urandom_range(0, 1));
         core_ready_i = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic load_iv(input logic [127:0] iv, input logic m);
      int k = 0;
      while (!iv_ready_o && k < 300) begin
         cyc();
         k++;
      end
      chk("iv_wait", 128'(iv_ready_o), 128'(1));
      iv_i     = iv;
      mode_i   = m;
      ivalid_i = 1'b1;
      cyc();
      ivalid_i = 1'b0;
   endtask

   task automatic push(input logic [127:0] d, input logic l);
      din_i    = d;
      dlast_i  = l;
      dvalid_i = 1'b1;
      for (int k = 0; k < 300; k++) begin
         cyc();
         if (last_in_hs) break;
      end
      chk("push_hs", 128'(last_in_hs), 128'(1));
      dvalid_i = 1'b0;
   endtask

   task automatic drain();
      dready_i = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if (n_out == n_in) break;
         cyc();
      end
      chk("drain_all", 128'(n_out), 128'(n_in));
   endtask

   typedef struct {
      bit           ivld;
      bit           mode;
      logic [127:0] iv;
      logic [127:0] din;
      bit           last;
      logic [127:0] cdin;
      logic [127:0] dout;
      int           cnt;
   } vec_t;

   vec_t vt[6];

   initial begin
      logic [127:0] cd, hold, prev;
      bit           got;
      int           nb;
      logic         m;

      resetn = 1'b0; enable_i = 1'b0; iv_i = '0; mode_i = 1'b0; ivalid_i = 1'b0;
      din_i = '0; dlast_i = 1'b0; dvalid_i = 1'b0; core_ready_i = 1'b1;
      core_valid_i = 1'b0; core_dout_i = '0; dready_i = 1'b0;

      vt[0] = '{1, 1, 128'h2,  128'h1,  1, 128'h3,  128'h3 ^ K,             1};
      vt[1] = '{1, 0, 128'h10, 128'h20, 0, 128'h20, 128'h20 ^ K ^ 128'h10, 1};
      vt[2] = '{0, 0, 128'h0,  128'h30, 0, 128'h30, 128'h30 ^ K ^ 128'h20, 2};
      vt[3] = '{0, 0, 128'h0,  128'h40, 1, 128'h40, 128'h40 ^ K ^ 128'h30, 3};
      vt[4] = '{1, 1, 128'hF0, 128'h0F, 0, 128'hFF, 128'hFF ^ K,            1};
      vt[5] = '{0, 1, 128'h0,  128'h01, 1, 128'h01 ^ 128'hFF ^ K, 128'hFE,  2};

      @(negedge clk);
      cyc();
      cyc();
      chk("rst_dout", dout_o, '0);
      chk("rst_dvalid", 128'(dvalid_o), '0);
      chk("rst_dlast", 128'(dlast_o), '0);
      chk("rst_cnt", 128'(blk_cnt_o), '0);
      chk("rst_busy", 128'(busy_o), '0);
      chk("rst_err", 128'(err_o), '0);
      chk("rst_start", 128'(core_start_o), '0);
      chk("rst_cdin", core_din_o, '0);
      chk("rst_ivrdy", 128'(iv_ready_o), '0);
      chk("rst_drdy", 128'(dready_o), '0);
      resetn   = 1'b1;
      enable_i = 1'b1;
      cyc();
      chk("idle_ivrdy", 128'(iv_ready_o), 128'(1));

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         if (vt[i].ivld) load_iv(vt[i].iv, vt[i].mode);
         dready_i = 1'b1;
         push(vt[i].din, vt[i].last);
         got = 0;
         cd  = '0;
         for (int k = 0; k < 40; k++) begin
            cyc();
            if (last_core_hs) cd = last_core_din;
            if (last_out_hs) begin
               got = 1;
               break;
            end
         end
         chk("vec_out_seen", 128'(got), 128'(1));
         chk("vec_core_din", cd, vt[i].cdin);
         chk("vec_dout", last_dout, vt[i].dout);
         chk("vec_dlast", 128'(last_dlast), 128'(vt[i].last));
         chk("vec_cnt", 128'(blk_cnt_o), 128'(vt[i].cnt));
         if (i == 0) begin
            chk("vec0_ivrdy", 128'(iv_ready_o), 128'(1));
            chk("vec0_busy", 128'(busy_o), '0);
         end
      end

      // Backpressure: 4 in FIFO + 1 in flight
      dready_i = 1'b0;
      load_iv(128'h1234_5678, 1'b1);
      for (int i = 0; i < 5; i++) push(128'(100 + i), i == 4);
      cyc();
      cyc();
      chk("bp_dready_low", 128'(dready_o), '0);
      chk("bp_dvalid", 128'(dvalid_o), 128'(1));
      hold = dout_o;
      for (int i = 0; i < 5; i++) cyc();
      chk("bp_dout_hold", dout_o, hold);
      chk("bp_dvalid_hold", 128'(dvalid_o), 128'(1));
      drain();
      chk("bp_cnt", 128'(blk_cnt_o), 128'(5));

      // Back-to-back: next message's blocks buffered before its IV
      dready_i = 1'b0;
      load_iv(128'hAAAA_0001, 1'b1);
      push(128'h11, 1'b0);
      push(128'h12, 1'b1);
      push(128'h21, 1'b0);
      push(128'h22, 1'b1);
      dready_i = 1'b1;
      for (int k = 0; k < 100 && !iv_ready_o; k++) cyc();
      for (int k = 0; k < 3; k++) cyc();
      chk("b2b_hold_dvalid", 128'(dvalid_o), '0);
      chk("b2b_hold_busy", 128'(busy_o), '0);
      chk("b2b_hold_ivrdy", 128'(iv_ready_o), 128'(1));
      load_iv(128'hBBBB_0002, 1'b0);
      drain();
      chk("b2b_cnt", 128'(blk_cnt_o), 128'(2));

      // Random traffic with random sink/core backpressure
      rnd = 1'b1;
      for (int msg = 0; msg < 8; msg++) begin
         m  = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 6);
         load_iv({$urandom, $urandom, $urandom, $urandom}, m);
         for (int b = 0; b < nb; b++) push({$urandom, $urandom, $urandom, $urandom}, b == nb - 1);
      end
      rnd = 1'b0;
      core_ready_i = 1'b1;
      drain();
      chk("rnd_err", 128'(err_o), '0);

      // Enable dropped across the result pulse
      dready_i = 1'b0;
      load_iv(128'h99, 1'b0);
      push(128'h1234, 1'b1);
      got = 0;
      for (int k = 0; k < 50; k++) begin
         cyc();
         if (last_core_hs) begin
            got = 1;
            break;
         end
      end
      chk("en_core_hs", 128'(got), 128'(1));
      enable_i = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("en_frozen_dvalid", 128'(dvalid_o), '0);
      chk("en_frozen_busy", 128'(busy_o), 128'(1));
      chk("en_start_low", 128'(core_start_o), '0);
      enable_i = 1'b1;
      drain();
      chk("en_err", 128'(err_o), '0);

      // Stray core result in READY
      load_iv(128'hAB, 1'b1);
      prev = dout_o;
      chk("pe_err_before", 128'(err_o), '0);
      inj = 1'b1;
      cyc();
      cyc();
      chk("pe_err_set", 128'(err_o), 128'(1));
      chk("pe_dvalid", 128'(dvalid_o), '0);
      chk("pe_dout", dout_o, prev);
      chk("pe_busy", 128'(busy_o), '0);
      push(128'hCD, 1'b1);
      drain();
      chk("pe_err_sticky", 128'(err_o), 128'(1));

      // Reset while waiting for the core
      dready_i = 1'b1;
      load_iv(128'h77, 1'b1);
      push(128'h5, 1'b1);
      got = 0;
      for (int k = 0; k < 50; k++) begin
         cyc();
         if (last_core_hs) begin
            got = 1;
            break;
         end
      end
      chk("rw_core_hs", 128'(got), 128'(1));
      chk("rw_busy", 128'(busy_o), 128'(1));
      resetn = 1'b0;
      #1;
      chk("rw_dout", dout_o, '0);
      chk("rw_dvalid", 128'(dvalid_o), '0);
      chk("rw_cnt", 128'(blk_cnt_o), '0);
      chk("rw_err", 128'(err_o), '0);
      chk("rw_busy0", 128'(busy_o), '0);
      chk("rw_cdin", core_din_o, '0);
      cyc();
      model_reset();
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      chk("rw_discard", 128'(dvalid_o), '0);
      chk("rw_ivrdy", 128'(iv_ready_o), 128'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
